mem_req_queue: RTL and testbench

MEM_REQ_QUEUE -- requirements
Module: mem_req_queue

---
 rtl/mem_req_queue.sv | 101 ++++++++++
 tb/tb_mem_req_queue.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_req_queue.sv
// mem_req_queue: 8-entry (2^DEPTH_LOG2) first-word-fall-through request queue.
// Each accepted request is tagged with a transaction ID taken from a free-running
// counter that advances only on accepted pushes.
//
// Ports:
//   clk, reset      clock; asynchronous active-low reset
//   req_valid/ready request handshake (ready = !full, from registered state)
//   req_rw/addr/data request payload
//   rd_en           downstream pop of the head entry
//   data_out        head entry {tid, rw, addr, data}; zero while empty
//   empty/full/count occupancy status
//   next_tid        ID the next accepted request receives
//   err_underflow   sticky: pop attempted while empty
module mem_req_queue #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 31,
  parameter int TID_WIDTH     = 16,
  parameter int DEPTH_LOG2    = 3,
  parameter int DP_DATA_WIDTH = TID_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_rw,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]    req_data,
  input  logic                     rd_en,
  output logic [DP_DATA_WIDTH-1:0] data_out,
  output logic                     empty,
  output logic                     full,
  output logic [DEPTH_LOG2:0]      count,
  output logic [TID_WIDTH-1:0]     next_tid,
  output logic                     err_underflow
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DP_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]    wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]      count_q,  count_d;
  logic [TID_WIDTH-1:0]     tid_q,    tid_d;
  logic                     err_q,    err_d;
  logic                     push, pop;

  // Status comes only from registered count, so no path from rd_en/req_valid.
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign req_ready = !full;
  assign count     = count_q;
  assign next_tid  = tid_q;
  assign err_underflow = err_q;

  // Head is masked while empty: stale storage (e.g. after a mid-run reset)
  // never leaks out, and an empty-queue push never bypasses to the output.
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    push     = req_valid && req_ready;
    pop      = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    tid_d    = tid_q;
    err_d    = err_q | (rd_en && empty);
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      tid_d    = tid_q + 1'b1;   // wraps naturally at 2^TID_WIDTH
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tid_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tid_q    <= tid_d;
      err_q    <= err_d;
    end
  end

  // Storage is not reset; visibility is governed by count/rd_ptr.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {tid_q, req_rw, req_addr, req_data};
  end

endmodule

// File: tb/tb_mem_req_queue.sv
module tb_mem_req_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_rw = 1'b0, rd_en = 1'b0;
  logic        req_ready, empty, full, err_underflow;
  logic [30:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [79:0] data_out;
  logic [3:0]  count;
  logic [15:0] next_tid;

  int checks = 0, failures = 0;

  // Reference model: plain queue of packed entries plus ID counter and sticky error.
  logic [79:0] mq[$];
  logic [15:0] m_tid = '0;
  bit          m_err = 1'b0;

  mem_req_queue dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data), .rd_en(rd_en),
    .data_out(data_out), .empty(empty), .full(full), .count(count),
    .next_tid(next_tid), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] exp_head();
    return (mq.size() != 0) ? mq[0] : 80'h0;
  endfunction

  // One clock: drive, advance model by the queue rules, settle to posedge+1.
  task automatic step(input bit v, input bit rw, input logic [30:0] a,
                      input logic [31:0] d, input bit rd);
    bit push, pop;
    req_valid = v; req_rw = rw; req_addr = a; req_data = d; rd_en = rd;
    @(posedge clk);
    push = v && (mq.size() < 8);
    pop  = rd && (mq.size() != 0);
    if (rd && mq.size() == 0) m_err = 1'b1;
    if (pop) void'(mq.pop_front());
    if (push) begin mq.push_back({m_tid, rw, a, d}); m_tid = m_tid + 16'd1; end
    #1;
    req_valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (next_tid !== 16'd0) begin failures++; $display("FAIL reset_tid got=%h exp=0", next_tid); end
    checks++; if (data_out !== 80'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_out); end
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_underflow); end
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [79:0] lit;
    lit = {16'h0000, 1'b1, 31'h10, 32'h7};
    step(1, 1, 31'h10, 32'h7, 0);
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL single_empty got=%b exp=0", empty); end
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
    checks++; if (data_out !== lit) begin failures++; $display("FAIL single_data got=%h exp=%h", data_out, lit); end
    checks++; if (next_tid !== 16'd1) begin failures++; $display("FAIL single_tid got=%h exp=1", next_tid); end
    step(0, 0, '0, '0, 1);
  endtask

  task automatic test_fill_drain();
    logic [15:0] tid0;
    tid0 = m_tid;
    for (int i = 0; i < 8; i++) step(1, $urandom_range(1), 31'($urandom), $urandom, 0);
    checks++; if (full !== 1'b1 || req_ready !== 1'b0 || count !== 4'd8) begin
      failures++; $display("FAIL fill_status got full=%b ready=%b count=%0d exp 1/0/8", full, req_ready, count); end
    step(1, 1, 31'h5, 32'h5, 0);
    checks++; if (next_tid !== tid0 + 16'd8 || count !== 4'd8) begin
      failures++; $display("FAIL fill_reject got tid=%h count=%0d exp tid=%h count=8", next_tid, count, tid0 + 16'd8); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (data_out[79:64] !== tid0 + 16'(i) || data_out !== exp_head()) begin
        failures++; $display("FAIL drain_order got=%h exp tid=%h entry=%h", data_out, tid0 + 16'(i), exp_head()); end
      step(0, 0, '0, '0, 1);
    end
    checks++; if (empty !== 1'b1 || data_out !== 80'h0) begin
      failures++; $display("FAIL drain_empty got empty=%b data=%h exp 1/0", empty, data_out); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_tid;
    for (int i = 0; i < 3; i++) step(1, 0, 31'($urandom), $urandom, 0);
    exp_tid = mq[0][79:64];
    for (int i = 0; i < 5; i++) begin
      checks++; if (data_out[79:64] !== exp_tid) begin
        failures++; $display("FAIL b2b_tid got=%h exp=%h", data_out[79:64], exp_tid); end
      step(1, 1, 31'($urandom), $urandom, 1);
      exp_tid = exp_tid + 16'd1;
      checks++; if (count !== 4'd3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", count); end
    end
    while (mq.size() != 0) step(0, 0, '0, '0, 1);
  endtask

  task automatic test_underflow();
    step(0, 0, '0, '0, 1);
    checks++; if (err_underflow !== 1'b1 || count !== 4'd0 || empty !== 1'b1) begin
      failures++; $display("FAIL underflow_set got err=%b count=%0d empty=%b exp 1/0/1", err_underflow, count, empty); end
    step(1, 0, 31'h22, 32'hABCD, 0);
    checks++; if (data_out !== exp_head() || count !== 4'd1) begin
      failures++; $display("FAIL underflow_ptrs got=%h count=%0d exp=%h count=1", data_out, count, exp_head()); end
    step(0, 0, '0, '0, 1);
    checks++; if (err_underflow !== 1'b1) begin failures++; $display("FAIL underflow_sticky got=%b exp=1", err_underflow); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1, 1, 31'($urandom), $urandom, 0);
    checks++; if (count !== 4'd5) begin failures++; $display("FAIL pre_reset_count got=%0d exp=5", count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (empty !== 1'b1 || count !== 4'd0 || next_tid !== 16'd0 || err_underflow !== 1'b0 || data_out !== 80'h0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL async_reset got empty=%b count=%0d tid=%h err=%b data=%h ready=%b", empty, count, next_tid, err_underflow, data_out, req_ready); end
    mq.delete(); m_tid = '0; m_err = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    // First edge after release must accept a push.
    step(1, 0, 31'h3, 32'h9, 0);
    checks++; if (count !== 4'd1 || data_out !== exp_head() || next_tid !== 16'd1) begin
      failures++; $display("FAIL post_reset_push got count=%0d data=%h tid=%h exp 1/%h/1", count, data_out, next_tid, exp_head()); end
  endtask

  task automatic test_tid_wrap();
    while (m_tid != 16'hFFFE) step(1, 0, 31'($urandom), $urandom, 1);
    while (mq.size() != 0) step(0, 0, '0, '0, 1);
    checks++; if (next_tid !== 16'hFFFE) begin failures++; $display("FAIL wrap_preload got=%h exp=fffe", next_tid); end
    step(1, 1, 31'h1, 32'h1, 0);
    step(1, 0, 31'h2, 32'h2, 0);
    checks++; if (next_tid !== 16'h0000) begin failures++; $display("FAIL wrap_tid got=%h exp=0000", next_tid); end
    checks++; if (data_out[79:64] !== 16'hFFFE || data_out !== exp_head()) begin
      failures++; $display("FAIL wrap_first got=%h exp tid fffe entry=%h", data_out, exp_head()); end
    step(0, 0, '0, '0, 1);
    checks++; if (data_out[79:64] !== 16'hFFFF || data_out !== exp_head()) begin
      failures++; $display("FAIL wrap_second got=%h exp tid ffff entry=%h", data_out, exp_head()); end
    step(0, 0, '0, '0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3) != 0, $urandom_range(1), 31'($urandom), $urandom, $urandom_range(2) == 0);
      checks++; if (data_out !== exp_head() || count !== 4'(mq.size()) || next_tid !== m_tid ||
                    empty !== (mq.size() == 0) || full !== (mq.size() == 8) ||
                    req_ready !== (mq.size() != 8) || err_underflow !== m_err) begin
        failures++;
        $display("FAIL random_cyc%0d got data=%h cnt=%0d tid=%h e=%b f=%b err=%b exp data=%h cnt=%0d tid=%h err=%b",
                 i, data_out, count, next_tid, empty, full, err_underflow, exp_head(), mq.size(), m_tid, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_underflow();
    test_async_reset();
    test_tid_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
